// File: rtl/plat_collide_scan.sv
// Sequential landing-platform scan: evaluates one platform slot per cycle and
// reports the highest platform the falling character lands on this frame.
module plat_collide_scan #(
    parameter int unsigned PLATFORM_NUM_PER_BLOCK = 7,
    parameter int unsigned PHY_WIDTH              = 16,
    parameter int unsigned BLOCK_LEN_WIDTH        = 4,
    parameter int unsigned TILE_W                 = 8,
    parameter int unsigned CHAR_W                 = 16
) (
    input  logic                                              sys_clk,
    input  logic                                              sys_rst,
    input  logic                                              start,
    input  logic [PHY_WIDTH-1:0]                              char_x,
    input  logic signed [PHY_WIDTH:0]                         char_y,
    input  logic signed [PHY_WIDTH:0]                         char_next_y,
    input  logic                                              falling,
    input  logic                                              block_switch,
    input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]       plat_relative_x,
    input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]       plat_relative_y,
    input  logic [PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH-1:0] plat_len,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              hit,
    output logic [2:0]                                        hit_idx,
    output logic [PHY_WIDTH-1:0]                              land_y
);

    localparam int unsigned XW       = PHY_WIDTH + 1;
    localparam logic [2:0]  LAST_IDX = 3'(PLATFORM_NUM_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                   state_q;
    logic [2:0]               cnt_q;
    logic [PHY_WIDTH-1:0]     cx_q;
    logic signed [XW-1:0]     cy_q;
    logic signed [XW-1:0]     cny_q;
    logic                     fall_q;
    logic                     best_v_q;
    logic [2:0]               best_idx_q;
    logic [PHY_WIDTH-1:0]     best_y_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     hit_q;
    logic [2:0]               hit_idx_q;
    logic [PHY_WIDTH-1:0]     land_y_q;

    logic [PHY_WIDTH-1:0]       sel_x;
    logic [PHY_WIDTH-1:0]       sel_y;
    logic [BLOCK_LEN_WIDTH-1:0] sel_len;
    logic [XW-1:0]              x_ext;
    logic [XW-1:0]              cx_ext;
    logic [XW-1:0]              right_edge;
    logic signed [XW-1:0]       y_ext;
    logic                       overlap;
    logic                       cand;
    logic                       take;
    logic                       best_v_d;
    logic [2:0]                 best_idx_d;
    logic [PHY_WIDTH-1:0]       best_y_d;

    // Select the slot addressed by the scan counter from the packed buses.
    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_len = '0;
        for (int i = 0; i < int'(PLATFORM_NUM_PER_BLOCK); i++) begin
            if (3'(i) == cnt_q) begin
                sel_x   = plat_relative_x[i*PHY_WIDTH +: PHY_WIDTH];
                sel_y   = plat_relative_y[i*PHY_WIDTH +: PHY_WIDTH];
                sel_len = plat_len[i*BLOCK_LEN_WIDTH +: BLOCK_LEN_WIDTH];
            end
        end
    end

    // Landing test for the current slot; extra bit keeps the edge sums from wrapping.
    always_comb begin
        x_ext      = {1'b0, sel_x};
        cx_ext     = {1'b0, cx_q};
        right_edge = x_ext + XW'(sel_len) * XW'(TILE_W);
        y_ext      = $signed({1'b0, sel_y});
        overlap    = ((cx_ext + XW'(CHAR_W)) > x_ext) && (cx_ext < right_edge);
        cand       = (sel_len != '0) && fall_q && overlap &&
                     (cy_q >= y_ext) && (cny_q <= y_ext);
        take       = cand && (!best_v_q || (sel_y > best_y_q));
        best_v_d   = best_v_q | cand;
        best_idx_d = take ? cnt_q : best_idx_q;
        best_y_d   = take ? sel_y : best_y_q;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            cny_q      <= '0;
            fall_q     <= 1'b0;
            best_v_q   <= 1'b0;
            best_idx_q <= '0;
            best_y_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hit_q      <= 1'b0;
            hit_idx_q  <= '0;
            land_y_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= SCAN;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        cx_q       <= char_x;
                        cy_q       <= char_y;
                        cny_q      <= char_next_y;
                        fall_q     <= falling;
                        best_v_q   <= 1'b0;
                        best_idx_q <= '0;
                        best_y_q   <= '0;
                    end
                end
                SCAN: begin
                    if (block_switch) begin
                        // Platform set changed under us: discard progress and rescan.
                        cnt_q      <= '0;
                        best_v_q   <= 1'b0;
                        best_idx_q <= '0;
                        best_y_q   <= '0;
                    end else if (cnt_q == LAST_IDX) begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        hit_q      <= best_v_d;
                        hit_idx_q  <= best_v_d ? best_idx_d : 3'd0;
                        land_y_q   <= best_v_d ? best_y_d : '0;
                        best_v_q   <= 1'b0;
                        best_idx_q <= '0;
                        best_y_q   <= '0;
                    end else begin
                        cnt_q      <= cnt_q + 3'd1;
                        best_v_q   <= best_v_d;
                        best_idx_q <= best_idx_d;
                        best_y_q   <= best_y_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign hit     = hit_q;
    assign hit_idx = hit_idx_q;
    assign land_y  = land_y_q;

endmodule

// File: tb/tb_plat_collide_scan.sv
// Directed bench for plat_collide_scan: hand-computed landing results, scan
// latency, start/block_switch/reset behaviour during a scan.
module tb_plat_collide_scan;

    logic              sys_clk;
    logic              sys_rst;
    logic              start;
    logic [15:0]       char_x;
    logic signed [16:0] char_y;
    logic signed [16:0] char_next_y;
    logic              falling;
    logic              block_switch;
    logic [111:0]      plat_relative_x;
    logic [111:0]      plat_relative_y;
    logic [27:0]       plat_len;
    logic              busy;
    logic              done;
    logic              hit;
    logic [2:0]        hit_idx;
    logic [15:0]       land_y;

    int n_cmp;
    int n_bad;

    plat_collide_scan dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .start           (start),
        .char_x          (char_x),
        .char_y          (char_y),
        .char_next_y     (char_next_y),
        .falling         (falling),
        .block_switch    (block_switch),
        .plat_relative_x (plat_relative_x),
        .plat_relative_y (plat_relative_y),
        .plat_len        (plat_len),
        .busy            (busy),
        .done            (done),
        .hit             (hit),
        .hit_idx         (hit_idx),
        .land_y          (land_y)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running, required to finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_slots();
        plat_relative_x = '0;
        plat_relative_y = '0;
        plat_len        = '0;
    endtask

    task automatic set_slot(input int i, input logic [15:0] x, input logic [15:0] y,
                            input logic [3:0] len);
        plat_relative_x[i*16 +: 16] = x;
        plat_relative_y[i*16 +: 16] = y;
        plat_len[i*4 +: 4]          = len;
    endtask

    task automatic set_char(input logic [15:0] x, input int y, input int ny, input logic f);
        char_x      = x;
        char_y      = 17'(y);
        char_next_y = 17'(ny);
        falling     = f;
    endtask

    // Full scan; char inputs are scrambled after accept to show they were latched.
    task automatic do_scan(input string tag, input logic bs_at_start, input logic exp_hit,
                           input logic [2:0] exp_idx, input logic [15:0] exp_y);
        logic [15:0]        sx;
        logic signed [16:0] sy, sny;
        logic               sf;
        int                 edges;
        sx = char_x; sy = char_y; sny = char_next_y; sf = falling;
        start = 1'b1;
        block_switch = bs_at_start;
        tick();
        start = 1'b0;
        block_switch = 1'b0;
        edges = 1;
        char_x = 16'd0; char_y = -17'sd500; char_next_y = 17'sd900; falling = ~sf;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        while (done !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        chk({tag, "_lat"}, 32'(edges), 32'd8);
        chk({tag, "_hit"}, 32'(hit), 32'(exp_hit));
        chk({tag, "_idx"}, 32'(hit_idx), 32'(exp_idx));
        chk({tag, "_y"}, 32'(land_y), 32'(exp_y));
        tick();
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
        char_x = sx; char_y = sy; char_next_y = sny; falling = sf;
    endtask

    initial begin
        int edges;
        int ndone;
        int first_done;
        n_cmp = 0;
        n_bad = 0;
        sys_rst = 1'b1;
        start = 1'b0;
        block_switch = 1'b0;
        set_char(16'd0, 0, 0, 1'b0);
        clear_slots();
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_idx", 32'(hit_idx), 32'd0);
        chk("rst_y", 32'(land_y), 32'd0);
        sys_rst = 1'b0;
        tick();

        // Basic landing on slot 0 and horizontal overlap boundaries.
        set_slot(0, 16'd250, 16'd60, 4'd10);
        set_char(16'd260, 62, 55, 1'b1);
        do_scan("basic", 1'b0, 1'b1, 3'd0, 16'd60);
        char_x = 16'd330;
        do_scan("right_edge", 1'b0, 1'b0, 3'd0, 16'd0);
        char_x = 16'd234;
        do_scan("left_edge", 1'b0, 1'b0, 3'd0, 16'd0);
        char_x = 16'd235;
        do_scan("left_in", 1'b0, 1'b1, 3'd0, 16'd60);

        // Start together with block_switch in IDLE still scans normally.
        char_x = 16'd260;
        do_scan("start_bs", 1'b0 | 1'b1, 1'b1, 3'd0, 16'd60);

        // block_switch alone in IDLE does nothing.
        block_switch = 1'b1;
        tick();
        block_switch = 1'b0;
        chk("bs_idle", {30'd0, busy, done}, 32'd0);

        // Highest platform wins; ties go to the lower index.
        clear_slots();
        set_slot(2, 16'd100, 16'd140, 4'd8);
        set_slot(5, 16'd100, 16'd120, 4'd8);
        set_char(16'd110, 150, 110, 1'b1);
        do_scan("multi", 1'b0, 1'b1, 3'd2, 16'd140);
        set_slot(5, 16'd100, 16'd140, 4'd8);
        do_scan("tie", 1'b0, 1'b1, 3'd2, 16'd140);
        set_slot(5, 16'd100, 16'd145, 4'd8);
        do_scan("higher", 1'b0, 1'b1, 3'd5, 16'd145);

        // Not falling, with start re-pulsed mid-scan: one done, no hit.
        clear_slots();
        set_slot(0, 16'd250, 16'd60, 4'd10);
        set_char(16'd260, 62, 55, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        ndone = 0;
        first_done = 0;
        falling = 1'b1;
        while (edges < 24) begin
            if (edges == 3 || edges == 6) start = 1'b1;
            if (edges == 4) chk("hold_hit", 32'(hit), 32'd1);
            tick();
            start = 1'b0;
            edges++;
            if (done === 1'b1) begin
                ndone++;
                if (first_done == 0) begin
                    first_done = edges;
                    chk("nofall_hit", 32'(hit), 32'd0);
                end
            end
        end
        chk("nofall_ndone", 32'(ndone), 32'd1);
        chk("nofall_lat", 32'(first_done), 32'd8);
        falling = 1'b1;

        // block_switch at SCAN cycle 3 restarts with the new platform set.
        set_char(16'd260, 62, 55, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        while (edges < 4) begin
            tick();
            edges++;
        end
        block_switch = 1'b1;
        clear_slots();
        set_slot(3, 16'd250, 16'd58, 4'd10);
        tick();
        edges++;
        block_switch = 1'b0;
        while (done !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        chk("bs_lat", 32'(edges), 32'd12);
        chk("bs_hit", 32'(hit), 32'd1);
        chk("bs_idx", 32'(hit_idx), 32'd3);
        chk("bs_y", 32'(land_y), 32'd58);
        tick();

        // Reset at SCAN cycle 4 aborts; outputs cleared, no done afterwards.
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        while (edges < 5) begin
            tick();
            edges++;
        end
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_hit", 32'(hit), 32'd0);
        chk("mrst_idx", 32'(hit_idx), 32'd0);
        chk("mrst_y", 32'(land_y), 32'd0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("mrst_ndone", 32'(ndone), 32'd0);
        do_scan("after_rst", 1'b0, 1'b1, 3'd3, 16'd58);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/plat_collide_scan.md
PLAT_COLLIDE_SCAN -- requirements
Module: plat_collide_scan

Interface
REQ-001 PLATFORM_NUM_PER_BLOCK, 7, platforms per block.
REQ-002 PHY_WIDTH, 16, coordinate width in pixels.
REQ-003 BLOCK_LEN_WIDTH, 4, platform length field width in tiles.
REQ-004 TILE_W, 8, pixels per platform tile.
REQ-005 CHAR_W, 16, character width in pixels.
REQ-006 sys_clk  in  1  single clock; all logic on rising edge.
REQ-007 sys_rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  scan request pulse; sampled only in IDLE.
REQ-009 char_x  in  PHY_WIDTH  block-relative left edge of character, unsigned.
REQ-010 char_y  in  PHY_WIDTH+1  block-relative feet y this frame, signed, y-up.
REQ-011 char_next_y  in  PHY_WIDTH+1  predicted feet y next frame, signed.
REQ-012 falling  in  1  vertical velocity <= 0.
REQ-013 block_switch  in  1  platform set changed this cycle.
REQ-014 plat_relative_x  in  PLATFORM_NUM_PER_BLOCK*PHY_WIDTH  packed platform left x, slot i at [i*PHY_WIDTH +: PHY_WIDTH].
REQ-015 plat_relative_y  in  PLATFORM_NUM_PER_BLOCK*PHY_WIDTH  packed platform top y.
REQ-016 plat_len  in  PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH  packed length in tiles.
REQ-017 busy  out  1  high in SCAN and DONE.
REQ-018 done  out  1  one-cycle result-valid pulse.
REQ-019 hit  out  1  a landing platform was found.
REQ-020 hit_idx  out  3  index of chosen platform.
REQ-021 land_y  out  PHY_WIDTH  top y of chosen platform.

Function
REQ-022 States IDLE, SCAN, DONE; IDLE->SCAN when start=1; SCAN->DONE after slot PLATFORM_NUM_PER_BLOCK-1 evaluated; DONE->IDLE unconditionally after one cycle.
REQ-023 Inputs char_x, char_y, char_next_y, falling are latched on the edge that accepts start; later changes do not affect the scan.
REQ-024 SCAN evaluates one slot per cycle, index 0 first, incrementing 3-bit counter; total accept-edge to done-high = 8 edges for 7 slots.
REQ-025 Slot i hits iff len_i != 0, falling latched = 1, horizontal overlap (char_x + CHAR_W > x_i) and (char_x < x_i + len_i*TILE_W), and char_y >= y_i and char_next_y <= y_i.
REQ-026 All overlap sums computed at PHY_WIDTH+1 bits unsigned, no wrap; y compares signed at PHY_WIDTH+1 bits with y_i zero-extended.
REQ-027 Among hits, keep the highest y_i; on equal y_i keep the lowest index (strict greater-than update).
REQ-028 hit, hit_idx, land_y are registered, update only on entry to DONE, and hold until the next DONE; done=1 only in DONE.
REQ-029 If no slot hits, DONE presents hit=0, hit_idx=0, land_y=0.
REQ-030 start while busy is ignored (not queued).
REQ-031 block_switch=1 during SCAN clears running best and restarts at slot 0 next cycle; latched char inputs retained; done delayed accordingly.
REQ-032 block_switch in IDLE or DONE has no effect.
REQ-033 start and block_switch simultaneously in IDLE: start is accepted, scan begins at slot 0.

Reset
REQ-034 sys_rst=1 on a rising edge forces IDLE, counter 0, busy=0, done=0, hit=0, hit_idx=0, land_y=0, running best cleared, regardless of state.
REQ-035 Reset mid-SCAN aborts without asserting done; first start after reset release scans normally.

Verification
REQ-036 Slot0 x=250 y=60 len=10, others len=0; char_x=260 y=62 next_y=55 falling=1, pulse start -> done 8 edges later, hit=1 hit_idx=0 land_y=60.
REQ-037 Same data, char_x=330 -> hit=0 (right edge 330 not < 330); char_x=234 -> hit=0 (234+16=250 not > 250); char_x=235 -> hit=1.
REQ-038 Slots 2 (x=100,y=140,len=8) and 5 (x=100,y=120,len=8) both overlapping char_x=110 y=150 next_y=110 -> hit_idx=2 land_y=140; set slot5 y=140 -> hit_idx=2 (tie, lowest index).
REQ-039 falling=0 with REQ-036 geometry -> hit=0; start pulsed again at cycles 2 and 5 of SCAN -> exactly one done pulse.
REQ-040 block_switch at SCAN cycle 3 -> done at 8+4=12 edges after accept, result reflects new platform data; sys_rst at SCAN cycle 4 -> no done, all outputs 0 next edge.
